instruction_memory_arbiter: RTL

- Two-master, one-slave Wishbone arbiter for the shared backing memory.
- Master 0 is the instruction cache refill port: read-only, block-wide.
- Master 1 is the data-side memory controller: read/write, block-wide with byte selects.
- Sits between both masters and the single memory slave. Registers the grant, locks the bus for the whole CYC of the winner, and routes ACK/data back only to the granted master.

---
 rtl/instruction_memory_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/instruction_memory_arbiter.sv
// Two-master / one-slave Wishbone arbiter for the shared backing memory.
// Master 0 (inst_*) is the read-only I-cache refill port, master 1 (data_*)
// is the read/write data-side controller. The grant is registered and held
// for the whole CYC of the winner; one dead IDLE cycle separates owners.
// Optional macro INSTRUCTION_ARBITER_ROUND_ROBIN_EN: when defined, contention
// alternates using last_grant; when undefined, the refill port always wins.
module instruction_memory_arbiter #(
  parameter int unsigned L2_BLOCK_SIZE = 6,
  parameter int unsigned L2_ADDR_SIZE  = 32
) (
  input  logic                                CLK_I,
  input  logic                                RST_I,
  input  logic                                inst_CYC_I,
  input  logic                                inst_STB_I,
  input  logic [L2_ADDR_SIZE-1:0]             inst_ADR_I,
  output logic [(2**(L2_BLOCK_SIZE+3))-1:0]   inst_DAT_O,
  output logic                                inst_ACK_O,
  input  logic                                data_CYC_I,
  input  logic                                data_STB_I,
  input  logic                                data_WE_I,
  input  logic [(2**L2_BLOCK_SIZE)-1:0]       data_SEL_I,
  input  logic [L2_ADDR_SIZE-1:0]             data_ADR_I,
  input  logic [(2**(L2_BLOCK_SIZE+3))-1:0]   data_DAT_I,
  output logic [(2**(L2_BLOCK_SIZE+3))-1:0]   data_DAT_O,
  output logic                                data_ACK_O,
  output logic                                mem_CYC_O,
  output logic                                mem_STB_O,
  output logic                                mem_WE_O,
  output logic [(2**L2_BLOCK_SIZE)-1:0]       mem_SEL_O,
  output logic [L2_ADDR_SIZE-1:0]             mem_ADR_O,
  output logic [(2**(L2_BLOCK_SIZE+3))-1:0]   mem_DAT_O,
  input  logic [(2**(L2_BLOCK_SIZE+3))-1:0]   mem_DAT_I,
  input  logic                                mem_ACK_I
);

  localparam int unsigned DW = 2**(L2_BLOCK_SIZE+3);
  localparam int unsigned SW = 2**L2_BLOCK_SIZE;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT_INST = 2'd1,
    GRANT_DATA = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_last_grant;      // 0 = instruction, 1 = data
  logic   w_last_grant_nxt;
  logic   w_pick_data;       // contention winner is the data master

  // Contention policy: alternate on last owner, or fixed refill priority
`ifdef INSTRUCTION_ARBITER_ROUND_ROBIN_EN
  assign w_pick_data = ~r_last_grant;
`else
  logic w_unused_last_grant;
  assign w_pick_data         = 1'b0;
  assign w_unused_last_grant = r_last_grant;
`endif

  // Read data fans out to both masters; each ACK qualifies its own copy
  assign inst_DAT_O = mem_DAT_I;
  assign data_DAT_O = mem_DAT_I;

  // Grant state and last owner, cleared asynchronously
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  // Arbitration, bus routing and ACK steering
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    mem_CYC_O        = 1'b0;
    mem_STB_O        = 1'b0;
    mem_WE_O         = 1'b0;
    mem_SEL_O        = '0;
    mem_ADR_O        = '0;
    mem_DAT_O        = '0;
    inst_ACK_O       = 1'b0;
    data_ACK_O       = 1'b0;

    case (r_state)
      IDLE: begin
        if (inst_CYC_I && data_CYC_I) begin
          w_state_nxt = w_pick_data ? GRANT_DATA : GRANT_INST;
        end else if (inst_CYC_I) begin
          w_state_nxt = GRANT_INST;
        end else if (data_CYC_I) begin
          w_state_nxt = GRANT_DATA;
        end
      end

      GRANT_INST: begin
        // Everything is gated by CYC so a release or abort drops the bus at once
        if (inst_CYC_I) begin
          mem_CYC_O  = 1'b1;
          mem_STB_O  = inst_STB_I;
          mem_SEL_O  = {SW{1'b1}};
          mem_ADR_O  = inst_ADR_I;
          inst_ACK_O = mem_ACK_I;
        end else begin
          w_state_nxt      = IDLE;
          w_last_grant_nxt = 1'b0;
        end
      end

      GRANT_DATA: begin
        if (data_CYC_I) begin
          mem_CYC_O  = 1'b1;
          mem_STB_O  = data_STB_I;
          mem_WE_O   = data_WE_I;
          mem_SEL_O  = data_SEL_I;
          mem_ADR_O  = data_ADR_I;
          mem_DAT_O  = data_DAT_I;
          data_ACK_O = mem_ACK_I;
        end else begin
          w_state_nxt      = IDLE;
          w_last_grant_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Width bookkeeping for the data bus
  logic [DW-1:0] w_unused_dw;
  assign w_unused_dw = '0;

endmodule
